// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi link BER checker.
// Holds the checker FSM state type and default sizing.
package viterbi_pkg;

    typedef enum logic {
        SEARCH,
        LOCKED
    } ber_state_e;

    localparam int DEF_DEPTH    = 32;
    localparam int DEF_WIN      = 16;
    localparam int DEF_LOCK_THR = 1;
    localparam int DEF_LOSS_THR = 4;
    localparam int DEF_CW       = 32;

endpackage

// File: rtl/tx_bit_history.sv
// Transmit bit history: shift register of raw encoder bits,
// saturating fill count, and a runtime-indexed tap.
module tx_bit_history
    import viterbi_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic          bit_in,
    input  logic [AW-1:0] idx,
    output logic          tap,
    output logic [FW-1:0] fill
);

    logic [DEPTH-1:0] hist;

    // newest bit enters at index 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
        end else if (shift) begin
            hist <= {hist[DEPTH-2:0], bit_in};
        end
    end

    // number of valid history bits, stops at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else if (shift && fill != FW'(DEPTH)) begin
            fill <= fill + 1'b1;
        end
    end

    // tap reads the pre-shift history
    always_comb begin
        tap = hist[idx];
    end

endmodule

// File: rtl/viterbi_ber_checker.sv
// End-of-link BER checker: searches for the decoder latency,
// then counts decoded bits, bit errors and lock losses.
module viterbi_ber_checker
    import viterbi_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIN      = DEF_WIN,
    parameter int LOCK_THR = DEF_LOCK_THR,
    parameter int LOSS_THR = DEF_LOSS_THR,
    parameter int CW       = DEF_CW,
    localparam int AW = $clog2(DEPTH),
    localparam int FW = $clog2(DEPTH + 1),
    localparam int WW = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          tx_valid_i,
    input  logic          tx_bit_i,
    input  logic          rx_valid_i,
    input  logic          rx_bit_i,
    output logic          locked_o,
    output logic [AW-1:0] lat_o,
    output logic          err_o,
    output logic [CW-1:0] bit_ct_o,
    output logic [CW-1:0] err_ct_o,
    output logic [7:0]    relock_ct_o
);

    ber_state_e    state;
    ber_state_e    state_nxt;
    logic [AW-1:0] cand;
    logic [AW-1:0] cand_nxt;
    logic [AW-1:0] lat_nxt;
    logic [AW-1:0] k;
    logic [WW-1:0] win_ct;
    logic [WW-1:0] win_nxt;
    logic [WW-1:0] mis_ct;
    logic [WW-1:0] mis_nxt;
    logic [WW-1:0] mis_sum;
    logic [FW-1:0] fill;
    logic          tap;
    logic          hit;
    logic          miss;
    logic          win_last;
    logic          drop;

    function automatic logic [AW-1:0] nxt_idx(input logic [AW-1:0] v);
        return (v == AW'(DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    tx_bit_history #(
        .DEPTH (DEPTH)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .shift  (tx_valid_i),
        .bit_in (tx_bit_i),
        .idx    (k),
        .tap    (tap),
        .fill   (fill)
    );

    // compare tap selection and counted-compare qualification
    always_comb begin
        k        = (state == LOCKED) ? lat_o : cand;
        hit      = rx_valid_i && (fill > FW'(k));
        miss     = hit && (rx_bit_i != tap);
        mis_sum  = mis_ct + WW'(miss);
        win_last = (win_ct == WW'(WIN - 1));
    end

    // next state, window bookkeeping and candidate stepping
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        lat_nxt   = lat_o;
        win_nxt   = win_ct;
        mis_nxt   = mis_ct;
        drop      = 1'b0;
        if (hit) begin
            unique case (state)
                SEARCH: begin
                    if (win_last) begin
                        win_nxt = '0;
                        mis_nxt = '0;
                        if (mis_sum <= WW'(LOCK_THR)) begin
                            state_nxt = LOCKED;
                            lat_nxt   = cand;
                        end else begin
                            cand_nxt = nxt_idx(cand);
                        end
                    end else begin
                        win_nxt = win_ct + 1'b1;
                        mis_nxt = mis_sum;
                    end
                end
                LOCKED: begin
                    if (miss && mis_sum >= WW'(LOSS_THR)) begin
                        state_nxt = SEARCH;
                        cand_nxt  = nxt_idx(lat_o);
                        drop      = 1'b1;
                        win_nxt   = '0;
                        mis_nxt   = '0;
                    end else if (win_last) begin
                        win_nxt = '0;
                        mis_nxt = '0;
                    end else begin
                        win_nxt = win_ct + 1'b1;
                        mis_nxt = mis_sum;
                    end
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // candidate, locked latency and window counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand   <= '0;
            lat_o  <= '0;
            win_ct <= '0;
            mis_ct <= '0;
        end else begin
            cand   <= cand_nxt;
            lat_o  <= lat_nxt;
            win_ct <= win_nxt;
            mis_ct <= mis_nxt;
        end
    end

    // locked statistics: saturating, clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o       <= 1'b0;
            bit_ct_o    <= '0;
            err_ct_o    <= '0;
            relock_ct_o <= '0;
        end else begin
            err_o <= (state == LOCKED) && miss;
            if (clr_i) begin
                bit_ct_o <= '0;
            end else if (state == LOCKED && hit && bit_ct_o != '1) begin
                bit_ct_o <= bit_ct_o + 1'b1;
            end
            if (clr_i) begin
                err_ct_o <= '0;
            end else if (state == LOCKED && miss && err_ct_o != '1) begin
                err_ct_o <= err_ct_o + 1'b1;
            end
            if (clr_i) begin
                relock_ct_o <= '0;
            end else if (drop && relock_ct_o != '1) begin
                relock_ct_o <= relock_ct_o + 1'b1;
            end
        end
    end

    // lock flag straight from the state register
    always_comb begin
        locked_o = (state == LOCKED);
    end

endmodule
